// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared access-size encoding, MMIO offsets and size decode helper
package data_mem_responder_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    localparam logic [3:0] MMIO_TOHOST   = 4'h0;
    localparam logic [3:0] MMIO_CYCLE_LO = 4'h4;
    localparam logic [3:0] MMIO_CYCLE_HI = 4'h8;
    localparam logic [3:0] MMIO_ERR      = 4'hC;

    function automatic logic size_valid(input logic [2:0] size);
        return size inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: core-to-responder data-memory bus
interface data_mem_responder_if;

    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_we;
    logic [2:0]  mem_size;
    logic [31:0] data_rdata;

    modport master (
        output data_addr, data_wdata, data_we, mem_size,
        input  data_rdata
    );

    modport slave (
        input  data_addr, data_wdata, data_we, mem_size,
        output data_rdata
    );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and lane extraction/extension for loads
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        size_ok
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Size decode, lane enables, store replication and load extension
    always_comb begin
        size_ok     = size_valid(size);
        misalign    = size_ok && ((size[1:0] == 2'b01 && addr_lo[0]) ||
                                  (size[1:0] == 2'b10 && addr_lo != 2'b00));
        be          = (!size_ok || misalign) ? 4'b0000 :
                      size[1:0] == 2'b00     ? 4'b0001 << addr_lo :
                      size[1:0] == 2'b01     ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                                               4'b1111;
        wdata_lanes = size[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                      size[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
        rbyte       = rword[8*addr_lo +: 8];
        rhalf       = addr_lo[1] ? rword[31:16] : rword[15:0];
        rdata       = (!size_ok || misalign) ? 32'h0 :
                      size == MEM_B  ? {{24{rbyte[7]}}, rbyte} :
                      size == MEM_BU ? {24'h0, rbyte} :
                      size == MEM_H  ? {{16{rhalf[15]}}, rhalf} :
                      size == MEM_HU ? {16'h0, rhalf} : rword;
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM with combinational reads plus TOHOST/cycle/error MMIO window
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic                 tohost_valid,
    output logic [31:0]          tohost_data,
    output logic                 misalign_err,
    output logic                 access_err
);

    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [63:0]   counter;
    logic [AW-1:0] idx;
    logic          ram_hit, mmio_hit, size_w;
    logic [31:0]   mmio_word, rword, al_rdata, wdata_lanes;
    logic [3:0]    be;
    logic          misalign, size_ok;
    logic          store_ok, ram_we, mmio_we, set_mis, set_acc;

    dmem_lane_align u_align (
        .addr_lo     (bus.data_addr[1:0]),
        .size        (bus.mem_size),
        .wdata       (bus.data_wdata),
        .rword       (rword),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .rdata       (al_rdata),
        .misalign    (misalign),
        .size_ok     (size_ok)
    );

    // Address decode, read mux and store qualification
    always_comb begin
        idx              = bus.data_addr[AW+1:2];
        ram_hit          = bus.data_addr[31:2] < 30'(DEPTH_WORDS);
        mmio_hit         = bus.data_addr[31:4] == MMIO_BASE[31:4];
        size_w           = bus.mem_size == MEM_W;
        mmio_word        = bus.data_addr[3:0] == MMIO_TOHOST   ? tohost_data :
                           bus.data_addr[3:0] == MMIO_CYCLE_LO ? counter[31:0] :
                           bus.data_addr[3:0] == MMIO_CYCLE_HI ? counter[63:32] :
                                                                 {30'h0, access_err, misalign_err};
        rword            = ram_hit ? ram[idx] : mmio_word;
        bus.data_rdata   = (ram_hit || (mmio_hit && size_w)) ? al_rdata : 32'h0;
        store_ok         = bus.data_we && size_ok && !misalign && (ram_hit || (mmio_hit && size_w));
        ram_we           = store_ok && ram_hit;
        mmio_we          = store_ok && !ram_hit;
        set_mis          = bus.data_we && misalign;
        set_acc          = bus.data_we && (!size_ok || !(ram_hit || mmio_hit) ||
                                           (!ram_hit && mmio_hit && !size_w));
    end

    // RAM byte-lane writes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we && be[i]) ram[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
    end

    // MMIO registers, sticky error flags and free-running cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_valid <= 1'b0;
            tohost_data  <= 32'h0;
            misalign_err <= 1'b0;
            access_err   <= 1'b0;
            counter      <= 64'h0;
        end else begin
            counter      <= counter + 64'h1;
            tohost_valid <= mmio_we && bus.data_addr[3:0] == MMIO_TOHOST;
            if (mmio_we && bus.data_addr[3:0] == MMIO_TOHOST) tohost_data <= bus.data_wdata;
            if (mmio_we && bus.data_addr[3:0] == MMIO_ERR) begin
                misalign_err <= 1'b0;
                access_err   <= 1'b0;
            end else begin
                misalign_err <= misalign_err | set_mis;
                access_err   <= access_err | set_acc;
            end
        end
    end

endmodule
